// File: rtl/tetris_key_decoder.sv
// PS/2 scan-code set 2 parser that turns make codes into 3-bit game events,
// queued in a small first-word-fall-through FIFO drained by the game logic.
module tetris_key_decoder #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] ps2_key_data_i,
    input  logic       ps2_key_data_en_i,
    input  logic       user_event_rd_req_i,
    output logic [2:0] user_event_o,
    output logic       user_event_ready_o,
    output logic       overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

    state_t        state_q;
    logic [TW-1:0] tmo_q;
    logic [2:0]    skip_q;

    logic          evt_push_d;
    logic [2:0]    evt_code_d;

    logic [AW:0]   wptr_q, rptr_q;
    logic [2:0]    mem_q [FIFO_DEPTH];
    logic          overflow_q;
    logic          empty, full, pop, wr;

    // Only complete make codes produce an event; breaks and prefixes never do.
    always_comb begin
        evt_push_d = 1'b0;
        evt_code_d = 3'd0;
        if (ps2_key_data_en_i) begin
            case (state_q)
                S_IDLE: begin
                    case (ps2_key_data_i)
                        8'h29:   begin evt_push_d = 1'b1; evt_code_d = 3'd4; end
                        8'h4D:   begin evt_push_d = 1'b1; evt_code_d = 3'd5; end
                        8'h5A:   begin evt_push_d = 1'b1; evt_code_d = 3'd6; end
                        default: ;
                    endcase
                end
                S_EXT: begin
                    case (ps2_key_data_i)
                        8'h6B:   begin evt_push_d = 1'b1; evt_code_d = 3'd0; end
                        8'h74:   begin evt_push_d = 1'b1; evt_code_d = 3'd1; end
                        8'h72:   begin evt_push_d = 1'b1; evt_code_d = 3'd2; end
                        8'h75:   begin evt_push_d = 1'b1; evt_code_d = 3'd3; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            skip_q  <= '0;
        end else if (ps2_key_data_en_i) begin
            tmo_q <= '0;
            case (state_q)
                S_IDLE: begin
                    case (ps2_key_data_i)
                        8'hE0:   state_q <= S_EXT;
                        8'hF0:   state_q <= S_BRK;
                        8'hE1:   begin state_q <= S_SKIP; skip_q <= 3'd7; end
                        default: state_q <= S_IDLE;
                    endcase
                end
                S_EXT:   state_q <= (ps2_key_data_i == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_SKIP: begin
                    if (skip_q <= 3'd1) begin
                        state_q <= S_IDLE;
                        skip_q  <= '0;
                    end else begin
                        skip_q <= skip_q - 3'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // Saturating idle timer abandons a stale prefix.
            if (tmo_q == TMO_LAST) begin
                state_q <= S_IDLE;
                skip_q  <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_ONE;
            end
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = user_event_rd_req_i && !empty;
    // A concurrent pop frees the head slot, so a push on full still fits.
    assign wr    = evt_push_d && (!full || pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr)  wptr_q <= wptr_q + PTR_ONE;
            if (pop) rptr_q <= rptr_q + PTR_ONE;
            overflow_q <= evt_push_d && full && !pop;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wptr_q[AW-1:0]] <= evt_code_d;
    end

    assign user_event_ready_o = !empty;
    assign user_event_o       = empty ? 3'd0 : mem_q[rptr_q[AW-1:0]];
    assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_tetris_key_decoder.sv
// Directed-vector bench for tetris_key_decoder with a short timeout.
module tb_tetris_key_decoder;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       en = 1'b0;
    logic       rd = 1'b0;
    logic [2:0] evt;
    logic       ready;
    logic       ovf;

    int n_tests = 0;
    int n_fail  = 0;

    tetris_key_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .ps2_key_data_i      (data),
        .ps2_key_data_en_i   (en),
        .user_event_rd_req_i (rd),
        .user_event_o        (evt),
        .user_event_ready_o  (ready),
        .overflow_o          (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Presents a byte for the next rising edge; consecutive calls are back-to-back.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        data = b;
        en   = 1'b1;
    endtask

    task automatic stop();
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pops every queued event, comparing against exp[0..n-1], then expects empty.
    task automatic drain(input string tag, input int exp [], input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_rdy"}, int'(ready), 1);
            check({tag, "_evt"}, int'(evt), exp[i]);
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
        end
        check({tag, "_empty"}, int'(ready), 0);
    endtask

    initial begin
        int e [];
        e = new[DEPTH];

        // reset state
        #12;
        check("rst_ready", int'(ready), 0);
        check("rst_evt", int'(evt), 0);
        check("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // extended make then extended break: one LEFT, ready the cycle after 6B
        send(8'hE0); send(8'h6B); stop();
        check("left_latency_rdy", int'(ready), 1);
        check("left_latency_evt", int'(evt), 0);
        send(8'hE0); send(8'hF0); send(8'h6B); stop();
        send(8'h29); stop();
        e[0] = 0; e[1] = 4;
        drain("left_break", e, 2);

        // plain makes with a break in between, popped on consecutive cycles
        send(8'h29); send(8'h4D); send(8'h5A); send(8'hF0); send(8'h29); stop();
        e[0] = 4; e[1] = 5; e[2] = 6;
        drain("plain", e, 3);

        // all four extended arrows
        send(8'hE0); send(8'h74); send(8'hE0); send(8'h72);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B); stop();
        e[0] = 1; e[1] = 2; e[2] = 3; e[3] = 0;
        drain("arrows", e, 4);

        // unknown extended code consumes the prefix; following 29 is plain
        send(8'hE0); send(8'h29); stop();
        check("ext_unknown", int'(ready), 0);
        send(8'h29); stop();
        e[0] = 4;
        drain("ext_unknown_after", e, 1);

        // pop on empty is ignored
        rd = 1'b1; @(negedge clk); rd = 1'b0;
        send(8'h5A); stop();
        e[0] = 6;
        drain("pop_empty", e, 1);

        // overflow: nine DROPs, ninth dropped with a single-cycle pulse
        for (int i = 0; i < 9; i++) send(8'h29);
        stop();
        check("ovf_pulse", int'(ovf), 1);
        @(negedge clk);
        check("ovf_clear", int'(ovf), 0);
        // push concurrent with pop on full: accepted, no overflow
        send(8'h5A);
        rd = 1'b1;
        @(negedge clk);
        en = 1'b0;
        rd = 1'b0;
        check("full_pushpop_ovf", int'(ovf), 0);
        for (int i = 0; i < 7; i++) e[i] = 4;
        e[7] = 6;
        drain("full_pushpop", e, 8);

        // timeout: E0 then TMO idle cycles, 29 is a plain DROP
        send(8'hE0); stop();
        idle(TMO - 1);
        send(8'h29); stop();
        e[0] = 4;
        drain("timeout", e, 1);

        // one cycle short of the timeout the prefix still applies
        send(8'hE0); stop();
        idle(TMO - 2);
        send(8'h74); stop();
        e[0] = 1;
        drain("no_timeout", e, 1);

        // pause sequence is skipped whole; trailing 75 is unknown in IDLE
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h75); stop();
        check("pause_none", int'(ready), 0);
        send(8'h4D); stop();
        e[0] = 5;
        drain("pause_idle", e, 1);

        // async reset mid-cycle with 3 events queued and FSM in EXT
        send(8'h29); send(8'h4D); send(8'h5A); send(8'hE0); stop();
        check("pre_rst_rdy", int'(ready), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rdy", int'(ready), 0);
        check("async_rst_evt", int'(evt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h74); stop();
        check("post_rst_74", int'(ready), 0);
        idle(2);
        check("post_rst_ovf", int'(ovf), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
